// File: rtl/robot_controller.sv
// Line-follower sequencer: shared PWM timebase, sensor synchroniser and steering FSM.
// Define ROBOT_CTL_LOST_SEARCH_EN to make LOST spin toward the last side seen.
module robot_controller #(
   parameter int unsigned PERIOD       = 2_000_000,
   parameter int unsigned LOST_PERIODS = 25
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        enable_i,
   input  logic [2:0]  sensor_i,
   output logic [20:0] count_out_o,
   output logic        motor_l_dir_o,
   output logic        motor_l_stop_o,
   output logic        motor_r_dir_o,
   output logic        motor_r_stop_o,
   output logic [2:0]  state_out_o
);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StForward = 3'd1,
      StGentleL = 3'd2,
      StSharpL  = 3'd3,
      StGentleR = 3'd4,
      StSharpR  = 3'd5,
      StLost    = 3'd6
   } state_e;

   localparam logic [20:0] CountMax = 21'(PERIOD - 1);
   localparam logic [7:0]  LostLim  = 8'(LOST_PERIODS);

   state_e      state_q, state_d;
   logic [20:0] count_q;
   logic [2:0]  sync1_q, sync2_q;
   logic [7:0]  lost_q, lost_d, lost_inc;
   logic        boundary;
   logic        l_stop_q, l_dir_q, r_stop_q, r_dir_q;
   logic        l_stop_d, l_dir_d, r_stop_d, r_dir_d;
`ifdef ROBOT_CTL_LOST_SEARCH_EN
   logic        last_left_q, last_left_d;
`endif

   assign boundary = (count_q == CountMax);
   assign lost_inc = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;

   always_comb begin
      state_d = state_q;
      lost_d  = lost_q;
      if (!enable_i) begin
         state_d = StIdle;
         lost_d  = '0;
      end else begin
         lost_d = '0;
         unique case (sync2_q)
            3'b010, 3'b111: state_d = StForward;
            3'b110:         state_d = StGentleL;
            3'b100:         state_d = StSharpL;
            3'b011:         state_d = StGentleR;
            3'b001:         state_d = StSharpR;
            3'b101: begin
               // Ambiguous pattern: keep steering, but a parked robot still starts.
               if (state_q == StIdle) state_d = StForward;
            end
            3'b000: begin
               lost_d = lost_inc;
               if (lost_inc >= LostLim) state_d = StLost;
            end
            default: state_d = state_q;
         endcase
      end
   end

`ifdef ROBOT_CTL_LOST_SEARCH_EN
   always_comb begin
      last_left_d = last_left_q;
      if (state_d == StGentleL || state_d == StSharpL) last_left_d = 1'b1;
      if (state_d == StGentleR || state_d == StSharpR) last_left_d = 1'b0;
   end
`endif

   always_comb begin
      {l_stop_d, l_dir_d, r_stop_d, r_dir_d} = 4'b1010;
      unique case (state_d)
         StIdle:    {l_stop_d, l_dir_d, r_stop_d, r_dir_d} = 4'b1010;
         StForward: {l_stop_d, l_dir_d, r_stop_d, r_dir_d} = 4'b0001;
         StGentleL: {l_stop_d, l_dir_d, r_stop_d, r_dir_d} = 4'b1001;
         StSharpL:  {l_stop_d, l_dir_d, r_stop_d, r_dir_d} = 4'b0101;
         StGentleR: {l_stop_d, l_dir_d, r_stop_d, r_dir_d} = 4'b0010;
         StSharpR:  {l_stop_d, l_dir_d, r_stop_d, r_dir_d} = 4'b0000;
         StLost: begin
`ifdef ROBOT_CTL_LOST_SEARCH_EN
            {l_stop_d, l_dir_d, r_stop_d, r_dir_d} = last_left_d ? 4'b0101 : 4'b0000;
`else
            {l_stop_d, l_dir_d, r_stop_d, r_dir_d} = 4'b1010;
`endif
         end
         default:   {l_stop_d, l_dir_d, r_stop_d, r_dir_d} = 4'b1010;
      endcase
   end

   // State and motor outputs only move on the wrap edge so no PWM pulse is cut short.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q  <= '0;
         sync1_q  <= '0;
         sync2_q  <= '0;
         state_q  <= StIdle;
         lost_q   <= '0;
         l_stop_q <= 1'b1;
         l_dir_q  <= 1'b0;
         r_stop_q <= 1'b1;
         r_dir_q  <= 1'b0;
`ifdef ROBOT_CTL_LOST_SEARCH_EN
         last_left_q <= 1'b0;
`endif
      end else begin
         count_q <= boundary ? '0 : count_q + 21'd1;
         sync1_q <= sensor_i;
         sync2_q <= sync1_q;
         if (boundary) begin
            state_q  <= state_d;
            lost_q   <= lost_d;
            l_stop_q <= l_stop_d;
            l_dir_q  <= l_dir_d;
            r_stop_q <= r_stop_d;
            r_dir_q  <= r_dir_d;
`ifdef ROBOT_CTL_LOST_SEARCH_EN
            last_left_q <= last_left_d;
`endif
         end
      end
   end

   assign count_out_o    = count_q;
   assign state_out_o    = state_q;
   assign motor_l_stop_o = l_stop_q;
   assign motor_l_dir_o  = l_dir_q;
   assign motor_r_stop_o = r_stop_q;
   assign motor_r_dir_o  = r_dir_q;

endmodule
